// File: rtl/fft_pkg.sv
// Shared widths and the range-limit helper for the FFT complex multiplier.
// Saturating versus wrapping output is chosen with the CMUL_SAT_EN macro (see cmul_round_sat).
package fft_pkg;

    localparam int CMUL_DATA_W = 16;
    localparam int CMUL_TW_W   = 16;
    localparam int CMUL_OUT_W  = 16;
    localparam int CMUL_FRAC_W = 15;

    // Wide enough for any rounded sum this multiplier can produce.
    localparam int LIM_W = 64;

    typedef struct packed {
        logic [LIM_W-1:0] val;
        logic             ovf;
    } sat_res_t;

    function automatic int cmul_prod_w(input int data_w, input int tw_w);
        return data_w + tw_w;
    endfunction

    function automatic int cmul_sum_w(input int data_w, input int tw_w);
        return data_w + tw_w + 2;
    endfunction

    // Clamp a signed value into out_w bits and report whether it was out of range.
    function automatic sat_res_t sat_limit(input logic signed [LIM_W-1:0] value, input int out_w);
        sat_res_t                res;
        logic signed [LIM_W-1:0] hi;
        logic signed [LIM_W-1:0] lo;
        hi      = (LIM_W'(1) <<< (out_w - 1)) - LIM_W'(1);
        lo      = -(LIM_W'(1) <<< (out_w - 1));
        res.val = value;
        res.ovf = 1'b0;
        if (value > hi) begin
            res.val = hi;
            res.ovf = 1'b1;
        end else if (value < lo) begin
            res.val = lo;
            res.ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// Round-half-up then range-limit one component of the complex product.
// CMUL_SAT_EN defined: clamp out-of-range results; undefined: keep the low OUT_W bits.
module cmul_round_sat
    import fft_pkg::*;
#(
    parameter int IN_W   = 34,
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 15
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    logic signed [LIM_W-1:0] din_ext;
    logic signed [LIM_W-1:0] rnd;
    sat_res_t                lim;

    assign din_ext = LIM_W'(din);
    assign rnd     = (din_ext + (LIM_W'(1) <<< (FRAC_W - 1))) >>> FRAC_W;
    assign lim     = sat_limit(rnd, OUT_W);
    assign ovf     = lim.ovf;

`ifdef CMUL_SAT_EN
    assign dout = lim.val[OUT_W-1:0];
`else
    assign dout = rnd[OUT_W-1:0];
`endif

endmodule

// File: rtl/cmplx_mul_pipe.sv
// Three-stage signed complex multiplier P = A*B or A*conj(B) with valid/ready backpressure.
// Output limiting mode is selected by CMUL_SAT_EN inside cmul_round_sat.
module cmplx_mul_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = CMUL_DATA_W,
    parameter int TW_W   = CMUL_TW_W,
    parameter int OUT_W  = CMUL_OUT_W,
    parameter int FRAC_W = CMUL_FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [TW_W-1:0]   b_re,
    input  logic signed [TW_W-1:0]   b_im,
    input  logic                     conj,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  p_re,
    output logic signed [OUT_W-1:0]  p_im,
    output logic                     p_ovf
);

    localparam int PROD_W = cmul_prod_w(DATA_W, TW_W);
    localparam int SUM_W  = cmul_sum_w(DATA_W, TW_W);
    localparam int BIM_W  = TW_W + 1;

    logic advance;

    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W-1:0] s1_ar_q, s1_ar_d, s1_ai_q, s1_ai_d;
    logic signed [TW_W-1:0]   s1_br_q, s1_br_d;
    logic signed [BIM_W-1:0]  s1_bi_q, s1_bi_d;

    logic                     s2_valid_q, s2_valid_d;
    logic signed [PROD_W-1:0] s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
    logic signed [PROD_W-1:0] s2_ri_q, s2_ri_d, s2_ir_q, s2_ir_d;

    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  p_re_q, p_re_d, p_im_q, p_im_d;
    logic                     p_ovf_q, p_ovf_d;

    logic signed [SUM_W-1:0]  sum   [2];
    logic signed [OUT_W-1:0]  lim   [2];
    logic                     ovf   [2];

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    assign sum[0] = SUM_W'(s2_rr_q) - SUM_W'(s2_ii_q);
    assign sum[1] = SUM_W'(s2_ri_q) + SUM_W'(s2_ir_q);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_round
            cmul_round_sat #(
                .IN_W   (SUM_W),
                .OUT_W  (OUT_W),
                .FRAC_W (FRAC_W)
            ) u_round_sat (
                .din  (sum[gi]),
                .dout (lim[gi]),
                .ovf  (ovf[gi])
            );
        end
    endgenerate

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_ar_d     = s1_ar_q;
        s1_ai_d     = s1_ai_q;
        s1_br_d     = s1_br_q;
        s1_bi_d     = s1_bi_q;
        s2_valid_d  = s2_valid_q;
        s2_rr_d     = s2_rr_q;
        s2_ii_d     = s2_ii_q;
        s2_ri_d     = s2_ri_q;
        s2_ir_d     = s2_ir_q;
        out_valid_d = out_valid_q;
        p_re_d      = p_re_q;
        p_im_d      = p_im_q;
        p_ovf_d     = p_ovf_q;
        if (advance) begin
            s1_valid_d  = in_valid;
            s1_ar_d     = a_re;
            s1_ai_d     = a_im;
            s1_br_d     = b_re;
            // conj is folded in here; one extra bit keeps -(-2^(TW_W-1)) from wrapping.
            s1_bi_d     = conj ? -BIM_W'(b_im) : BIM_W'(b_im);
            s2_valid_d  = s1_valid_q;
            s2_rr_d     = PROD_W'(s1_ar_q) * PROD_W'(s1_br_q);
            s2_ii_d     = PROD_W'(s1_ai_q) * PROD_W'(s1_bi_q);
            s2_ri_d     = PROD_W'(s1_ar_q) * PROD_W'(s1_bi_q);
            s2_ir_d     = PROD_W'(s1_ai_q) * PROD_W'(s1_br_q);
            out_valid_d = s2_valid_q;
            p_re_d      = lim[0];
            p_im_d      = lim[1];
            p_ovf_d     = ovf[0] | ovf[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_ar_q     <= '0;
            s1_ai_q     <= '0;
            s1_br_q     <= '0;
            s1_bi_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_rr_q     <= '0;
            s2_ii_q     <= '0;
            s2_ri_q     <= '0;
            s2_ir_q     <= '0;
            out_valid_q <= 1'b0;
            p_re_q      <= '0;
            p_im_q      <= '0;
            p_ovf_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ar_q     <= s1_ar_d;
            s1_ai_q     <= s1_ai_d;
            s1_br_q     <= s1_br_d;
            s1_bi_q     <= s1_bi_d;
            s2_valid_q  <= s2_valid_d;
            s2_rr_q     <= s2_rr_d;
            s2_ii_q     <= s2_ii_d;
            s2_ri_q     <= s2_ri_d;
            s2_ir_q     <= s2_ir_d;
            out_valid_q <= out_valid_d;
            p_re_q      <= p_re_d;
            p_im_q      <= p_im_d;
            p_ovf_q     <= p_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p_re      = p_re_q;
    assign p_im      = p_im_q;
    assign p_ovf     = p_ovf_q;

endmodule
